// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver, 16x oversampled from an internal divider.
//               Delivers each byte with a one-cycle valid strobe (rx_status)
//               or a one-cycle framing-error strobe (rx_err).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int unsigned TICK_DIV = 27
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       rx_err,
  output logic       rx_busy
);

  localparam logic [15:0] C_TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [3:0]  C_OS_MID    = 4'd7;
  localparam logic [3:0]  C_OS_LAST   = 4'd15;
  localparam logic [3:0]  C_BIT_LAST  = 4'd7;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_rx_meta;
  logic        r_rx_s;
  logic [15:0] r_tick_cnt;
  logic [3:0]  r_os_cnt;
  logic [3:0]  r_bit_cnt;
  logic [7:0]  r_shreg;
  logic [7:0]  r_rx_data;
  logic        r_rx_status;
  logic        r_rx_err;
  logic        w_tick;
  logic        w_state_chg;
  logic        w_shift_en;
  logic        w_load_data;
  logic        w_frame_err;

  // Two-flop synchronizer; idles high so reset does not look like a start bit.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Oversample tick: one pulse every TICK_DIV cycles while a frame is active.
  assign w_tick = (r_state != S_IDLE) && (r_tick_cnt == C_TICK_LAST);

  // Tick divider, parked at zero in IDLE so each frame starts phase-aligned.
  always_ff @(posedge sysclk) begin
    if (reset || (r_state == S_IDLE) || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 16'd1;
    end
  end

  assign w_state_chg = (w_state_next != r_state);

  // Oversample position within the current bit; restarts on every state change.
  always_ff @(posedge sysclk) begin
    if (reset || w_state_chg) begin
      r_os_cnt <= '0;
    end else if (w_tick) begin
      r_os_cnt <= r_os_cnt + 4'd1;
    end
  end

  // Data-bit counter and LSB-first shift register.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_bit_cnt <= '0;
      r_shreg   <= '0;
    end else begin
      if (w_state_chg && (w_state_next == S_DATA)) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
      if (w_shift_en) begin
        r_shreg <= {r_rx_s, r_shreg[7:1]};
      end
    end
  end

  // Output byte register and registered one-cycle strobes.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_rx_data   <= '0;
      r_rx_status <= 1'b0;
      r_rx_err    <= 1'b0;
    end else begin
      if (w_load_data) begin
        r_rx_data <= r_shreg;
      end
      r_rx_status <= w_load_data;
      r_rx_err    <= w_frame_err;
    end
  end

  // FSM state register.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and datapath control.
  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_load_data  = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        // Mid start bit: a high line here means the falling edge was a glitch.
        if (w_tick && (r_os_cnt == C_OS_MID)) begin
          w_state_next = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_tick && (r_os_cnt == C_OS_LAST)) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == C_BIT_LAST) begin
            w_state_next = S_STOP;
          end
        end
      end
      S_STOP: begin
        // Leaving at mid stop bit lets a back-to-back start edge be caught.
        if (w_tick && (r_os_cnt == C_OS_LAST)) begin
          if (r_rx_s) begin
            w_load_data  = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        // A break or stuck-low line must return high before a new frame.
        if (r_rx_s) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign rx_data   = r_rx_data;
  assign rx_status = r_rx_status;
  assign rx_err    = r_rx_err;
  assign rx_busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Self-checking bench for uart_receiver with a byte scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  localparam int TICK_DIV = 4;
  localparam int BIT_P    = 16 * TICK_DIV;

  logic       sysclk  = 1'b0;
  logic       reset   = 1'b1;
  logic       uart_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       rx_err;
  logic       rx_busy;

  int         n_cmp      = 0;
  int         n_fail     = 0;
  int         status_cnt = 0;
  int         err_cnt    = 0;
  bit         ignore_strobes = 1'b0;
  bit         prev_strobe    = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  uart_receiver #(.TICK_DIV(TICK_DIV)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .rx_err    (rx_err),
    .rx_busy   (rx_busy)
  );

  always #5 sysclk = ~sysclk;

  // Scoreboard monitor: pops one expected byte per rx_status strobe.
  always @(negedge sysclk) begin
    if (rx_status === 1'b1 || rx_err === 1'b1) begin
      n_cmp++;
      if (rx_status === 1'b1 && rx_err === 1'b1) begin
        n_fail++;
        $display("FAIL strobe_exclusive: status=%0b err=%0b, required not both high", rx_status, rx_err);
      end
      n_cmp++;
      if (prev_strobe) begin
        n_fail++;
        $display("FAIL strobe_width: strobe high on consecutive cycles at %0t, required single-cycle", $time);
      end
    end
    if (rx_status === 1'b1) begin
      status_cnt++;
      if (!ignore_strobes) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_byte: got 0x%02h, required no rx_status", rx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (rx_data !== exp_b) begin
            n_fail++;
            $display("FAIL rx_data_sb: got 0x%02h, required 0x%02h", rx_data, exp_b);
          end
        end
      end
    end
    if (rx_err === 1'b1) err_cnt++;
    prev_strobe = (rx_status === 1'b1) || (rx_err === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // Drives one frame; the line is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] b, input int period, input logic stop_lvl);
    uart_rx = 1'b0;
    tick(period);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(period);
    end
    uart_rx = stop_lvl;
    tick(period);
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    uart_rx = 1'b1;
    tick(3);
    n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got 0x%02h, required 0x00", rx_data); end
    n_cmp++; if (rx_status !== 1'b0) begin n_fail++; $display("FAIL reset_status: got %0b, required 0", rx_status); end
    n_cmp++; if (rx_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b, required 0", rx_err); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b, required 0", rx_busy); end
    reset = 1'b0;
    tick(8);
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %0b, required 0", rx_busy); end
  endtask

  task automatic test_single;
    int s0, e0;
    s0 = status_cnt; e0 = err_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, BIT_P, 1'b1);
    tick(BIT_P);
    n_cmp++; if (status_cnt - s0 != 1) begin n_fail++; $display("FAIL single_pulses: got %0d, required 1", status_cnt - s0); end
    n_cmp++; if (err_cnt != e0) begin n_fail++; $display("FAIL single_err: got %0d, required 0", err_cnt - e0); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got 0x%02h, required 0xa5", rx_data); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %0b, required 0", rx_busy); end
  endtask

  task automatic test_back_to_back;
    int s0, e0;
    logic [7:0] bytes [3];
    bytes = '{8'h00, 8'hFF, 8'h3C};
    s0 = status_cnt; e0 = err_cnt;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(bytes[i]);
      send_frame(bytes[i], BIT_P, 1'b1);
    end
    tick(BIT_P);
    n_cmp++; if (status_cnt - s0 != 3) begin n_fail++; $display("FAIL b2b_pulses: got %0d, required 3", status_cnt - s0); end
    n_cmp++; if (err_cnt != e0) begin n_fail++; $display("FAIL b2b_err: got %0d, required 0", err_cnt - e0); end
    n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_pending: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_glitch;
    int s0, e0;
    s0 = status_cnt; e0 = err_cnt;
    uart_rx = 1'b0;
    tick(10);
    n_cmp++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_start: busy got %0b, required 1", rx_busy); end
    tick(10);
    uart_rx = 1'b1;
    tick(BIT_P);
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: busy got %0b, required 0", rx_busy); end
    n_cmp++; if (status_cnt != s0 || err_cnt != e0) begin
      n_fail++; $display("FAIL glitch_strobe: status %0d err %0d, required 0 0", status_cnt - s0, err_cnt - e0);
    end
    exp_q.push_back(8'h55);
    send_frame(8'h55, BIT_P, 1'b1);
    tick(BIT_P);
    n_cmp++; if (status_cnt - s0 != 1) begin n_fail++; $display("FAIL glitch_next: pulses got %0d, required 1", status_cnt - s0); end
    n_cmp++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL glitch_data: got 0x%02h, required 0x55", rx_data); end
  endtask

  task automatic test_framing_error;
    int s0, e0;
    s0 = status_cnt; e0 = err_cnt;
    send_frame(8'h81, BIT_P, 1'b0);
    tick(3 * BIT_P);
    n_cmp++; if (err_cnt - e0 != 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d, required 1", err_cnt - e0); end
    n_cmp++; if (status_cnt != s0) begin n_fail++; $display("FAIL ferr_status: got %0d, required 0", status_cnt - s0); end
    n_cmp++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL ferr_data: got 0x%02h, required 0x55", rx_data); end
    n_cmp++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL ferr_wait: busy got %0b, required 1", rx_busy); end
    uart_rx = 1'b1;
    tick(8);
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_release: busy got %0b, required 0", rx_busy); end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, BIT_P, 1'b1);
    tick(BIT_P);
    n_cmp++; if (status_cnt - s0 != 1) begin n_fail++; $display("FAIL ferr_recover: pulses got %0d, required 1", status_cnt - s0); end
  endtask

  task automatic test_reset_mid_frame;
    int s0;
    logic [7:0] b;
    b = 8'hC3;
    ignore_strobes = 1'b1;
    uart_rx = 1'b0;
    tick(BIT_P);
    for (int i = 0; i < 4; i++) begin
      uart_rx = b[i];
      tick(BIT_P);
    end
    uart_rx = b[4];
    tick(BIT_P / 2);
    reset = 1'b1;
    tick(1);
    n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got 0x%02h, required 0x00", rx_data); end
    n_cmp++; if (rx_status !== 1'b0) begin n_fail++; $display("FAIL midrst_status: got %0b, required 0", rx_status); end
    n_cmp++; if (rx_err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %0b, required 0", rx_err); end
    n_cmp++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %0b, required 0", rx_busy); end
    reset = 1'b0;
    tick(BIT_P - BIT_P / 2 - 1);
    for (int i = 5; i < 8; i++) begin
      uart_rx = b[i];
      tick(BIT_P);
    end
    uart_rx = 1'b1;
    tick(13 * BIT_P);
    ignore_strobes = 1'b0;
    s0 = status_cnt;
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, BIT_P, 1'b1);
    tick(BIT_P);
    n_cmp++; if (status_cnt - s0 != 1) begin n_fail++; $display("FAIL midrst_next: pulses got %0d, required 1", status_cnt - s0); end
    n_cmp++; if (rx_data !== 8'h7E) begin n_fail++; $display("FAIL midrst_next_data: got 0x%02h, required 0x7e", rx_data); end
  endtask

  task automatic test_baud_skew;
    int periods [2];
    int s0;
    periods = '{61, 67};
    for (int i = 0; i < 2; i++) begin
      s0 = status_cnt;
      exp_q.push_back(8'h96);
      send_frame(8'h96, periods[i], 1'b1);
      tick(2 * BIT_P);
      n_cmp++; if (status_cnt - s0 != 1) begin n_fail++; $display("FAIL skew_%0d_pulses: got %0d, required 1", periods[i], status_cnt - s0); end
      n_cmp++; if (rx_data !== 8'h96) begin n_fail++; $display("FAIL skew_%0d_data: got 0x%02h, required 0x96", periods[i], rx_data); end
    end
  endtask

  initial begin
    @(negedge sysclk);
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_framing_error;
    test_reset_mid_frame;
    test_baud_skew;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d bytes never received, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver. It is the receive end of the team's 8N1 UART link and mirrors the transmitter's frame.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), at 16x oversampling.
- Runs entirely on the system clock. It derives the 16x sample tick internally from a divider instead of taking a separate baud clock.
- Sits between the board RX pin and the CPU's UART peripheral registers. It delivers each byte with a one-cycle valid strobe and a framing-error strobe.

Parameters:
- TICK_DIV, 27, number of sysclk cycles per 16x oversample tick (e.g. 50 MHz / (115200*16)). Legal range 2..65535.

Ports:
- sysclk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- uart_rx  input  1  asynchronous serial line, idle high.
- rx_data  output  8  last correctly framed byte; holds its value between frames.
- rx_status  output  1  one-cycle pulse: rx_data updated this cycle.
- rx_err  output  1  one-cycle pulse: stop bit sampled low (framing error).
- rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: synchronous, active-high. It is sampled on the sysclk edge and overrides everything, including a frame in progress.
  - After reset: rx_data=0, rx_status=0, rx_err=0, rx_busy=0, FSM=IDLE.
  - Synchronizer flops=1; tick, oversample and bit counters=0; shift register=0.
  - A reset in mid-frame discards the partial byte. No strobe is issued.
- Input synchronizer: two flops. rx_s is the second flop. All decisions use rx_s only, which adds 2 cycles of input latency.
- Tick generator: 16-bit counter.
  - Held at 0 in IDLE.
  - Otherwise counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle the count equals TICK_DIV-1.
- Oversample counter os_cnt: 4 bits. Increments on tick and wraps 15->0. Cleared on every state transition.
- FSM states:
  - IDLE: when rx_s==0, go to START; clear tick counter and os_cnt.
  - START: on a tick where os_cnt==7 (mid start bit):
    - rx_s==0: go to DATA, os_cnt=0, bit_cnt=0.
    - rx_s==1: treat as a glitch and return to IDLE silently.
  - DATA: on a tick where os_cnt==15 (mid bit):
    - shift in rx_s, LSB first: shreg <= {rx_s, shreg[7:1]}; bit_cnt++.
    - After the 8th bit (bit_cnt reaches 8), go to STOP with os_cnt=0.
  - STOP: on a tick where os_cnt==15:
    - rx_s==1: rx_data<=shreg, rx_status=1 for that one cycle, go to IDLE.
    - rx_s==0: rx_err=1 for that one cycle, rx_data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break or stuck-low line from retriggering.
- Strobes:
  - rx_status and rx_err are registered. They are never both high and never high two consecutive cycles.
  - Consumers must capture rx_data on rx_status. rx_data is stable until the next rx_status.
- Latency: rx_status rises on the sysclk edge after the mid-stop-bit tick. That is about 9.5 bit periods plus 2-3 cycles after the start-bit falling edge.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge arriving immediately after the stop bit is accepted with no gap required.
- Tolerance: sampling at mid-bit tolerates about ±4% combined baud mismatch.

Test Plan:
- Common setup: TICK_DIV=4, so one bit period is 64 sysclk cycles.
  - Drive 0xA5 as 8N1 -> exactly one rx_status pulse; rx_data=0xA5; rx_err never high; rx_busy low after the pulse.
  - Drive 0x00, 0xFF and 0x3C back-to-back with zero idle between them -> three rx_status pulses in order; rx_data matches each byte at its pulse.
- Glitch: a 20-cycle low pulse on an idle line -> FSM returns to IDLE; no rx_status, no rx_err; a following 0x55 frame is received correctly.
- Framing error: send 0x81 with the stop bit held low, then hold the line low for 3 bit periods, then high -> one rx_err pulse; rx_data keeps its previous value; no new frame starts until the line has gone high and then low again.
- Reset mid-frame: assert reset for 1 cycle during data bit 4 of 0xC3 -> all outputs 0 on the next cycle; no strobe. The remainder of the frame is treated per the FSM rules: no valid byte results from the partial frame, and any stray strobe is ignored by the checker. A subsequent clean 0x7E frame is received correctly.
- Baud skew: transmit 0x96 with a bit period of 61 and then 67 cycles (about ±4.7%) -> rx_data=0x96 in both cases.
